fetch_stage: RTL and testbench

- Three-wide in-order instruction fetch stage; owns the architectural fetch PC.
- Each cycle it drives three consecutive word addresses to the I-cache controller and receives up to three instructions with per-slot valid bits.
- It accepts the longest valid leading run of instructions, reports that count to the I-cache as shift, and registers the resulting packet for dispatch.
- Handles redirects from the back end and all-or-nothing dispatch stalls.

---
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Three-wide in-order fetch stage: owns the fetch PC, accepts the
// leading run of I-cache hits and registers the packet for dispatch.
//
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   stall                dispatch cannot accept the packet this cycle
//   take_branch          back-end redirect request
//   target_pc            redirect target (4-byte aligned)
//   Icache_data_out      instructions; slot 2 is the oldest
//   Icache_valid_out     per-slot hit valid
//   proc2Icache_addr     slot 2 = PC, slot 1 = PC+4, slot 0 = PC+8
//   shift                count of leading hits consumed (0..3)
//   if_inst/if_pc        registered packet, per slot
//   if_valid             registered slot valid (prefix from slot 2)
//   if_npc               registered PC after the last valid slot
//   perf_fetched         FETCH_PERF_CNT_EN only: instructions fetched
//   perf_miss_cycles     FETCH_PERF_CNT_EN only: cycles with < 3 hits
//
// Build option: define FETCH_PERF_CNT_EN to add the two saturating
// performance counters. Without it those ports and their logic are absent.

`ifndef XLEN
`define XLEN 32
`endif

module fetch_stage #(
  parameter int XLEN = `XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 take_branch,
  input  logic [XLEN-1:0]      target_pc,
  input  logic [2:0][31:0]     Icache_data_out,
  input  logic [2:0]           Icache_valid_out,
  output logic [2:0][XLEN-1:0] proc2Icache_addr,
  output logic [1:0]           shift,
  output logic [2:0][31:0]     if_inst,
  output logic [2:0][XLEN-1:0] if_pc,
  output logic [2:0]           if_valid,
  output logic [XLEN-1:0]      if_npc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]      perf_fetched,
  output logic [XLEN-1:0]      perf_miss_cycles
`endif
);

  logic [XLEN-1:0] pc;
  logic [2:0][XLEN-1:0] slot_pc;
  logic v2, v1, v0;
  logic [2:0] vmask;
  logic [1:0] count;
  logic fire;
  logic [XLEN-1:0] next_pc;
  logic [2:0][31:0] inst_masked;

  // Slot addresses; arithmetic wraps at 2^XLEN.
  always_comb begin
    slot_pc[2] = pc;
    slot_pc[1] = pc + XLEN'(4);
    slot_pc[0] = pc + XLEN'(8);
  end

  assign proc2Icache_addr = slot_pc;

  // Only the unbroken run of hits starting at the oldest slot is used;
  // a hit behind a miss would reorder the stream and is dropped.
  assign v2 = Icache_valid_out[2];
  assign v1 = v2 & Icache_valid_out[1];
  assign v0 = v1 & Icache_valid_out[0];
  assign vmask = {v2, v1, v0};

  assign count = 2'({1'b0, v2} + {1'b0, v1} + {1'b0, v0});

  // A cycle consumes cache data only when nothing overrides it.
  assign fire = !reset && !take_branch && !stall;

  assign shift = fire ? count : 2'd0;

  assign next_pc = pc + XLEN'({count, 2'b00});

  // Invalid slots carry zero so a stray read is harmless downstream.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      inst_masked[i] = vmask[i] ? Icache_data_out[i] : 32'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      if_valid <= '0;
      if_inst  <= '0;
      if_pc    <= '0;
      if_npc   <= RESET_PC;
    end else if (take_branch) begin
      pc       <= target_pc;
      if_valid <= '0;
      if_npc   <= target_pc;
    end else if (!stall) begin
      // count == 0 leaves pc unchanged, so the same addresses are
      // presented again until the fill lands.
      pc       <= next_pc;
      if_valid <= vmask;
      if_inst  <= inst_masked;
      if_pc    <= slot_pc;
      if_npc   <= next_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN:0] fetched_sum;

  assign fetched_sum = {1'b0, perf_fetched} + (XLEN+1)'(count);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched     <= '0;
      perf_miss_cycles <= '0;
    end else if (fire) begin
      // Saturate rather than wrap so long runs stay meaningful.
      perf_fetched <= fetched_sum[XLEN] ? '1 : fetched_sum[XLEN-1:0];
      if (count != 2'd3 && perf_miss_cycles != '1) begin
        perf_miss_cycles <= perf_miss_cycles + XLEN'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Linear steps; expected values are hand-computed constants.

module tb_fetch_stage;

  logic              clock;
  logic              reset;
  logic              stall;
  logic              take_branch;
  logic [31:0]       target_pc;
  logic [2:0][31:0]  Icache_data_out;
  logic [2:0]        Icache_valid_out;
  logic [2:0][31:0]  proc2Icache_addr;
  logic [1:0]        shift;
  logic [2:0][31:0]  if_inst;
  logic [2:0][31:0]  if_pc;
  logic [2:0]        if_valid;
  logic [31:0]       if_npc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_miss_cycles;
`endif

  int total;
  int passed;
  int failed;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .take_branch      (take_branch),
    .target_pc        (target_pc),
    .Icache_data_out  (Icache_data_out),
    .Icache_valid_out (Icache_valid_out),
    .proc2Icache_addr (proc2Icache_addr),
    .shift            (shift),
    .if_inst          (if_inst),
    .if_pc            (if_pc),
    .if_valid         (if_valid),
    .if_npc           (if_npc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_miss_cycles (perf_miss_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] v,
                       input logic [31:0] d2,
                       input logic [31:0] d1,
                       input logic [31:0] d0);
    Icache_valid_out = v;
    Icache_data_out[2] = d2;
    Icache_data_out[1] = d1;
    Icache_data_out[0] = d0;
  endtask

  initial begin
    total = 0;
    passed = 0;
    failed = 0;
    reset = 1'b1;
    stall = 1'b0;
    take_branch = 1'b0;
    target_pc = 32'h0;
    drive(3'b000, 32'h0, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b0;

    check("rst_valid", {29'd0, if_valid}, 32'h0);
    check("rst_inst2", if_inst[2], 32'h0);
    check("rst_pc2", if_pc[2], 32'h0);
    check("rst_npc", if_npc, 32'h0);
    check("rst_addr2", proc2Icache_addr[2], 32'h0);
    check("rst_addr1", proc2Icache_addr[1], 32'h4);
    check("rst_addr0", proc2Icache_addr[0], 32'h8);

    // Three hits from reset.
    drive(3'b111, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003);
    #1;
    check("hit3_shift", {30'd0, shift}, 32'd3);
    step();
    check("hit3_valid", {29'd0, if_valid}, 32'h7);
    check("hit3_pc2", if_pc[2], 32'h0);
    check("hit3_pc1", if_pc[1], 32'h4);
    check("hit3_pc0", if_pc[0], 32'h8);
    check("hit3_inst2", if_inst[2], 32'hAAAA_0001);
    check("hit3_inst0", if_inst[0], 32'hCCCC_0003);
    check("hit3_npc", if_npc, 32'hC);
    check("hit3_addr2", proc2Icache_addr[2], 32'hC);

    // Redirect to 0x100; cache data is dropped.
    take_branch = 1'b1;
    target_pc = 32'h100;
    #1;
    check("br_shift", {30'd0, shift}, 32'd0);
    step();
    take_branch = 1'b0;
    check("br_valid", {29'd0, if_valid}, 32'h0);
    check("br_npc", if_npc, 32'h100);
    check("br_addr2", proc2Icache_addr[2], 32'h100);

    // Hit behind a miss is discarded.
    drive(3'b101, 32'hDDDD_0004, 32'hEEEE_0005, 32'hFFFF_0006);
    #1;
    check("gap_shift", {30'd0, shift}, 32'd1);
    step();
    check("gap_valid", {29'd0, if_valid}, 32'h4);
    check("gap_inst2", if_inst[2], 32'hDDDD_0004);
    check("gap_inst1", if_inst[1], 32'h0);
    check("gap_inst0", if_inst[0], 32'h0);
    check("gap_pc0", if_pc[0], 32'h108);
    check("gap_npc", if_npc, 32'h104);
    check("gap_addr2", proc2Icache_addr[2], 32'h104);

    // Full miss for five cycles: addresses repeat.
    drive(3'b000, 32'h1, 32'h2, 32'h3);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("miss_shift", {30'd0, shift}, 32'd0);
      check("miss_addr2", proc2Icache_addr[2], 32'h104);
      check("miss_addr0", proc2Icache_addr[0], 32'h10C);
      step();
      check("miss_valid", {29'd0, if_valid}, 32'h0);
    end
    drive(3'b111, 32'h1111_0007, 32'h2222_0008, 32'h3333_0009);
    step();
    check("fill_valid", {29'd0, if_valid}, 32'h7);
    check("fill_pc2", if_pc[2], 32'h104);
    check("fill_npc", if_npc, 32'h110);
    check("fill_addr2", proc2Icache_addr[2], 32'h110);

    // Stall holds everything for two cycles.
    stall = 1'b1;
    drive(3'b111, 32'h4444_000A, 32'h5555_000B, 32'h6666_000C);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_shift", {30'd0, shift}, 32'd0);
      step();
      check("stall_inst2", if_inst[2], 32'h1111_0007);
      check("stall_valid", {29'd0, if_valid}, 32'h7);
      check("stall_addr2", proc2Icache_addr[2], 32'h110);
    end
    stall = 1'b0;
    #1;
    check("rel_shift", {30'd0, shift}, 32'd3);
    step();
    check("rel_pc2", if_pc[2], 32'h110);
    check("rel_inst2", if_inst[2], 32'h4444_000A);
    check("rel_addr2", proc2Icache_addr[2], 32'h11C);

    // Redirect wins over stall.
    stall = 1'b1;
    take_branch = 1'b1;
    target_pc = 32'h400;
    #1;
    check("brst_shift", {30'd0, shift}, 32'd0);
    step();
    stall = 1'b0;
    take_branch = 1'b0;
    check("brst_valid", {29'd0, if_valid}, 32'h0);
    check("brst_npc", if_npc, 32'h400);
    check("brst_addr2", proc2Icache_addr[2], 32'h400);
    check("brst_addr1", proc2Icache_addr[1], 32'h404);
    check("brst_addr0", proc2Icache_addr[0], 32'h408);

    // Address wrap at the top of memory.
    take_branch = 1'b1;
    target_pc = 32'hFFFF_FFFC;
    step();
    take_branch = 1'b0;
    check("wrap_addr1", proc2Icache_addr[1], 32'h0);
    drive(3'b111, 32'h7, 32'h8, 32'h9);
    step();
    check("wrap_pc2", if_pc[2], 32'hFFFF_FFFC);
    check("wrap_pc1", if_pc[1], 32'h0);
    check("wrap_pc0", if_pc[0], 32'h4);
    check("wrap_npc", if_npc, 32'h8);
    check("wrap_addr2", proc2Icache_addr[2], 32'h8);

`ifdef FETCH_PERF_CNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("perf_rst", perf_fetched, 32'd0);
    drive(3'b111, 32'h1, 32'h2, 32'h3);
    step();
    drive(3'b100, 32'h1, 32'h2, 32'h3);
    step();
    drive(3'b000, 32'h1, 32'h2, 32'h3);
    step();
    stall = 1'b1;
    drive(3'b111, 32'h1, 32'h2, 32'h3);
    step();
    stall = 1'b0;
    check("perf_fetched", perf_fetched, 32'd4);
    check("perf_miss", perf_miss_cycles, 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
